mem_dma: RTL and testbench

Single-channel block-copy engine sitting beside `mem_ctrl`. On a start request it stalls the core, takes ownership of the memory controller's read and write ports, and copies `len` bytes from `src` to `dst` within the current bank. It overlaps the read of byte k+1 with the write of byte k. When the copy ends it hands the ports back and re-presents the core's held read address so the core resumes with valid `readdata`.

---
 rtl/mem_dma_pkg.sv | 25 ++
 rtl/mem_dma_addrgen.sv | 46 ++++
 rtl/mem_dma.sv | 129 ++++++++++++
 tb/tb_mem_dma.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: shared types and constants for the mem_dma block-copy engine.
package mem_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT   = 3'd1,
    ST_RD0     = 3'd2,
    ST_COPY    = 3'd3,
    ST_LAST    = 3'd4,
    ST_RESTORE = 3'd5
  } dma_state_t;

  localparam logic [7:0] ADDR_STATUS  = 8'h01;
  localparam logic [7:0] ADDR_PROT_LO = 8'h01;
  localparam logic [7:0] ADDR_PROT_HI = 8'h07;

  // GRANT + RD0 + RESTORE on top of the per-byte cycles
  localparam int unsigned PAUSE_OVERHEAD = 3;

  // True for the special-function registers a DMA write must never touch
  function automatic logic addr_protected(input logic [7:0] a);
    return (a >= ADDR_PROT_LO) && (a <= ADDR_PROT_HI);
  endfunction

endpackage

// File: rtl/mem_dma_addrgen.sv
// mem_dma_addrgen: read/write address counters (8-bit wrap) and the
// remaining-read counter that flags the final read of a transfer.
module mem_dma_addrgen
  import mem_dma_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [7:0] i_src,
  input  logic [7:0] i_dst,
  input  logic [7:0] i_len,
  input  logic       i_rd_issue,
  input  logic       i_rd_adv,
  input  logic       i_wr_adv,
  output logic [7:0] o_rd_addr,
  output logic [7:0] o_wr_addr,
  output logic       o_last
);

  logic [7:0] r_rd;
  logic [7:0] r_wr;
  logic [7:0] r_rem;

  // Counters: load on start, then step as reads/writes are issued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_rem <= '0;
    end else if (i_load) begin
      r_rd  <= i_src;
      r_wr  <= i_dst;
      r_rem <= i_len;
    end else begin
      if (i_rd_adv)                  r_rd  <= r_rd + 8'd1;
      if (i_wr_adv)                  r_wr  <= r_wr + 8'd1;
      if (i_rd_issue && r_rem != '0) r_rem <= r_rem - 8'd1;
    end
  end

  assign o_rd_addr = r_rd;
  assign o_wr_addr = r_wr;
  // The read presented this cycle is the final one
  assign o_last    = (r_rem == 8'd1);

endmodule

// File: rtl/mem_dma.sv
// mem_dma: single-channel block-copy engine beside mem_ctrl.
// Optional write protection of 0x01..0x07 is enabled by MEM_DMA_PROTECT_EN.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int unsigned MAX_LEN = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] src,
  input  logic [7:0] dst,
  input  logic [7:0] len,
  input  logic       abort,
  input  logic [7:0] mem_readdata,
  output logic       core_pause,
  output logic       dma_own,
  output logic [7:0] mem_readaddr,
  output logic [7:0] mem_writeaddr,
  output logic [7:0] mem_writedata,
  output logic       mem_write_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] xfer_count
);

  localparam logic [7:0] LEN_CAP = (MAX_LEN > 255) ? 8'd255 : 8'(MAX_LEN);

  dma_state_t r_state;
  dma_state_t w_next;
  logic       r_zdone;
  logic [7:0] r_xfer;

  logic [7:0] w_len_eff;
  logic       w_accept;
  logic       w_zero;
  logic       w_last;
  logic [7:0] w_rd_addr;
  logic [7:0] w_wr_addr;
  logic       w_rd_issue;
  logic       w_wr_slot;
  logic       w_block;

  assign w_len_eff  = (len > LEN_CAP) ? LEN_CAP : len;
  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_zero     = (w_len_eff == '0);
  assign w_rd_issue = (r_state == ST_RD0) || (r_state == ST_COPY);
  assign w_wr_slot  = (r_state == ST_COPY) || (r_state == ST_LAST);

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept && !w_zero) w_next = ST_GRANT;
      ST_GRANT:   w_next = abort ? ST_RESTORE : ST_RD0;
      ST_RD0:     w_next = (abort || w_last) ? ST_LAST : ST_COPY;
      ST_COPY:    w_next = (abort || w_last) ? ST_LAST : ST_COPY;
      ST_LAST:    w_next = ST_RESTORE;
      ST_RESTORE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Read address only advances into another COPY cycle, so LAST keeps
  // presenting the address already in flight instead of a new one.
  mem_dma_addrgen u_addrgen (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_accept && !w_zero),
    .i_src      (src),
    .i_dst      (dst),
    .i_len      (w_len_eff),
    .i_rd_issue (w_rd_issue),
    .i_rd_adv   (w_rd_issue && (w_next == ST_COPY)),
    .i_wr_adv   (r_state == ST_COPY),
    .o_rd_addr  (w_rd_addr),
    .o_wr_addr  (w_wr_addr),
    .o_last     (w_last)
  );

  // Zero-length completion pulse and write-slot counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zdone <= 1'b0;
      r_xfer  <= '0;
    end else begin
      r_zdone <= w_accept && w_zero;
      if (w_accept)       r_xfer <= '0;
      else if (w_wr_slot) r_xfer <= r_xfer + 8'd1;
    end
  end

`ifdef MEM_DMA_PROTECT_EN
  logic r_err;

  assign w_block = addr_protected(w_wr_addr);

  // Sticky violation flag, cleared by the next accepted start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_err <= 1'b0;
    else if (w_accept)             r_err <= 1'b0;
    else if (w_wr_slot && w_block) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign w_block = 1'b0;
  assign err     = 1'b0;
`endif

  assign busy          = (r_state != ST_IDLE);
  assign core_pause    = (r_state != ST_IDLE);
  assign dma_own       = w_rd_issue || (r_state == ST_LAST);
  assign mem_readaddr  = dma_own ? w_rd_addr : '0;
  assign mem_writeaddr = w_wr_slot ? w_wr_addr : '0;
  // Data path is a direct bypass of mem_ctrl read data during write slots
  assign mem_writedata = w_wr_slot ? mem_readdata : '0;
  assign mem_write_en  = w_wr_slot && !w_block;
  assign done          = (r_state == ST_RESTORE) || r_zdone;
  assign xfer_count    = r_xfer;

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: scoreboard bench for mem_dma with a small mem_ctrl memory model.
module tb_mem_dma;
  import mem_dma_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] src = '0, dst = '0, len = '0;
  logic       abort = 1'b0;
  logic [7:0] mem_readdata = '0;
  logic       core_pause, dma_own, mem_write_en, busy, done, err;
  logic [7:0] mem_readaddr, mem_writeaddr, mem_writedata, xfer_count;

  mem_dma #(.MAX_LEN(255)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src(src), .dst(dst),
    .len(len), .abort(abort), .mem_readdata(mem_readdata),
    .core_pause(core_pause), .dma_own(dma_own), .mem_readaddr(mem_readaddr),
    .mem_writeaddr(mem_writeaddr), .mem_writedata(mem_writedata),
    .mem_write_en(mem_write_en), .busy(busy), .done(done), .err(err),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  // mem_ctrl model: synchronous read, core address held at 0x10
  logic [7:0] mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_a = '0, pl_d = '0;
  logic [7:0] core_ra = 8'h10;

  always @(posedge clk) begin
    mem_readdata <= mem[dma_own ? mem_readaddr : core_ra];
    if (pl_en)             mem[pl_a] <= pl_d;
    else if (mem_write_en) mem[mem_writeaddr] <= mem_writedata;
  end

  typedef struct { int cyc; logic [7:0] addr; logic [7:0] data; } wr_exp_t;
  typedef struct { int cyc; logic [7:0] cnt; int pause; logic err; } dn_exp_t;

  wr_exp_t wq[$];
  dn_exp_t dq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pause_run = 0;
  int ts;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops an expectation whenever the DUT writes or signals done
  wr_exp_t we;
  dn_exp_t de;
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      pause_run = 0;
    end else begin
      if (core_pause) pause_run++;
      if (mem_write_en) begin
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL wr_unexpected cyc=%0d addr=%h data=%h required none", cyc, mem_writeaddr, mem_writedata);
        end else begin
          we = wq.pop_front();
          if (we.cyc != cyc || we.addr != mem_writeaddr || we.data != mem_writedata) begin
            bad++;
            $display("FAIL wr cyc/addr/data got %0d/%h/%h required %0d/%h/%h",
                     cyc, mem_writeaddr, mem_writedata, we.cyc, we.addr, we.data);
          end
        end
      end
      if (done) begin
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected cyc=%0d required none", cyc);
        end else begin
          de = dq.pop_front();
          if (de.cyc != cyc || de.cnt != xfer_count || de.pause != pause_run || de.err != err) begin
            bad++;
            $display("FAIL done cyc/count/pause/err got %0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                     cyc, xfer_count, pause_run, err, de.cyc, de.cnt, de.pause, de.err);
          end
        end
        pause_run = 0;
      end
    end
  end

  task automatic push_wr(input int c, input logic [7:0] a, input logic [7:0] d);
    wr_exp_t e;
    e.cyc = c; e.addr = a; e.data = d;
    wq.push_back(e);
  endtask

  task automatic push_dn(input int c, input logic [7:0] n, input int p, input logic e_err);
    dn_exp_t e;
    e.cyc = c; e.cnt = n; e.pause = p; e.err = e_err;
    dq.push_back(e);
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Call at a negedge after the expectations are pushed
  task automatic fire(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((wq.size() != 0 || dq.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (wq.size() != 0 || dq.size() != 0) begin
      bad++;
      $display("FAIL %s pending wr=%0d done=%0d required 0/0", name, wq.size(), dq.size());
      wq.delete();
      dq.delete();
    end
  endtask

  task automatic check8(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  logic [31:0] w_outs;
  assign w_outs = {core_pause, dma_own, mem_write_en, busy, done, err,
                   mem_readaddr, mem_writeaddr, mem_writedata} | {24'd0, xfer_count};

  initial begin
    for (int i = 0; i < 256; i++) begin
      preload(8'(i), 8'h00);
    end
    preload(8'h20, 8'h11); preload(8'h21, 8'h22);
    preload(8'h22, 8'h33); preload(8'h23, 8'h44);
    preload(8'h24, 8'h55); preload(8'h25, 8'h66);
    preload(8'h26, 8'h77); preload(8'h27, 8'h88);
    preload(8'h28, 8'h99); preload(8'h29, 8'hAA);
    preload(8'hFE, 8'hA1); preload(8'hFF, 8'hB2);
    preload(8'h00, 8'hC3); preload(8'h01, 8'h55);

    check8("reset_outputs", w_outs, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 4-byte copy 0x20 -> 0x40
    ts = cyc;
    push_wr(ts+3, 8'h40, 8'h11); push_wr(ts+4, 8'h41, 8'h22);
    push_wr(ts+5, 8'h42, 8'h33); push_wr(ts+6, 8'h43, 8'h44);
    push_dn(ts+7, 8'd4, 7, 1'b0);
    fire(8'h20, 8'h40, 8'd4);
    wait_quiet("basic_copy");
    check8("basic_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'h11223344);

    // zero length
    ts = cyc;
    push_dn(ts+1, 8'd0, 0, 1'b0);
    fire(8'h20, 8'h40, 8'd0);
    wait_quiet("zero_len");

    // wrap-around source
    ts = cyc;
    push_wr(ts+3, 8'h80, 8'hA1); push_wr(ts+4, 8'h81, 8'hB2);
    push_wr(ts+5, 8'h82, 8'hC3);
    push_dn(ts+6, 8'd3, 6, 1'b0);
    fire(8'hFE, 8'h80, 8'd3);
    wait_quiet("wrap");

    // abort in 3rd COPY cycle of a 10-byte transfer
    ts = cyc;
    push_wr(ts+3, 8'h50, 8'h11); push_wr(ts+4, 8'h51, 8'h22);
    push_wr(ts+5, 8'h52, 8'h33); push_wr(ts+6, 8'h53, 8'h44);
    push_dn(ts+7, 8'd4, 7, 1'b0);
    fire(8'h20, 8'h50, 8'd10);
    while (cyc < ts+5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check8("abort_last_rdaddr", {23'd0, dma_own, mem_readaddr}, {23'd0, 1'b1, 8'h23});
    wait_quiet("abort");

    // start re-asserted during COPY is ignored
    ts = cyc;
    push_wr(ts+3, 8'h60, 8'h11); push_wr(ts+4, 8'h61, 8'h22);
    push_wr(ts+5, 8'h62, 8'h33); push_wr(ts+6, 8'h63, 8'h44);
    push_dn(ts+7, 8'd4, 7, 1'b0);
    fire(8'h20, 8'h60, 8'd4);
    while (cyc < ts+4) @(negedge clk);
    src = 8'h00; dst = 8'h70; len = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_quiet("restart_ignored");

    // write into the protected register window
    ts = cyc;
`ifdef MEM_DMA_PROTECT_EN
    push_wr(ts+3, 8'h00, 8'h11);
    push_dn(ts+7, 8'd4, 7, 1'b1);
`else
    push_wr(ts+3, 8'h00, 8'h11); push_wr(ts+4, 8'h01, 8'h22);
    push_wr(ts+5, 8'h02, 8'h33); push_wr(ts+6, 8'h03, 8'h44);
    push_dn(ts+7, 8'd4, 7, 1'b0);
`endif
    fire(8'h20, 8'h00, 8'd4);
    wait_quiet("protect");
`ifdef MEM_DMA_PROTECT_EN
    check8("status_kept", {24'd0, mem[ADDR_STATUS]}, 32'h55);
    check8("err_sticky", {31'd0, err}, 32'd1);
`else
    check8("status_written", {24'd0, mem[ADDR_STATUS]}, 32'h22);
    check8("err_tied", {31'd0, err}, 32'd0);
`endif
    ts = cyc;
    push_wr(ts+3, 8'h90, 8'h11);
    push_dn(ts+4, 8'd1, 4, 1'b0);
    fire(8'h20, 8'h90, 8'd1);
    wait_quiet("err_clear");

    // asynchronous reset in the middle of COPY
    ts = cyc;
    push_wr(ts+3, 8'hA0, 8'h11); push_wr(ts+4, 8'hA1, 8'h22);
    fire(8'h20, 8'hA0, 8'd8);
    while (cyc < ts+4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check8("async_reset_outputs", w_outs, 32'd0);
    @(negedge clk);
    check8("held_reset_outputs", w_outs, 32'd0);
    check8("reset_wr_consumed", wq.size(), 32'd0);
    wq.delete();
    dq.delete();
    reset_n = 1'b1;
    @(negedge clk);
    ts = cyc;
    push_wr(ts+3, 8'hB0, 8'h11);
    push_dn(ts+4, 8'd1, 4, 1'b0);
    fire(8'h20, 8'hB0, 8'd1);
    wait_quiet("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
